// File: rtl/memory_board.sv
// memory_board: turn controller for a 16-card memory game.
// A cursor walks the board, two picks per turn are presented to an external
// checker, and its verdict either retires the pair or shows it for a while
// before the turn passes to the other player.
// Optional feature: define TURN_TIMEOUT_EN to end a turn after TURN_TIMEOUT
// idle cycles in the pick phase.
module memory_board #(
    parameter logic [63:0] LAYOUT       = 64'h0123_4567_7654_3210,
    parameter int unsigned HOLD_CYCLES  = 25_000_000,
    parameter int unsigned TURN_TIMEOUT = 250_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_next,
    input  logic        btn_sel,
    input  logic        par,
    input  logic [1:0]  x,
    output logic [7:0]  counter,
    output logic [3:0]  state,
    output logic        select,
    output logic        empty,
    output logic        player,
    output logic [15:0] card_open,
    output logic [15:0] card_done,
    output logic        game_over
);

    typedef enum logic [2:0] {
        FIRST,
        SECOND,
        CHECK,
        SHOW,
        GAME_OVER
    } fsm_t;

    fsm_t        fsm;
    logic [3:0]  cursor;
    logic [3:0]  first_idx;
    logic [3:0]  second_idx;
    logic [31:0] hold;
    logic [3:0]  cursor_inc;
    logic [15:0] pair_mask;
    logic        in_pick;
    logic        pick_ok;
    logic        next_ok;

    function automatic logic [3:0] card_value(input logic [3:0] idx);
        return LAYOUT[{idx, 2'b00} +: 4];
    endfunction

    assign counter    = {4'b0000, cursor};
    assign empty      = ~(card_open[cursor] | card_done[cursor]);
    assign cursor_inc = cursor + 4'd1;
    assign pair_mask  = (16'd1 << first_idx) | (16'd1 << second_idx);
    assign in_pick    = (fsm == FIRST) || (fsm == SECOND);
    // A pick right after a select pulse is refused so pulses never abut.
    assign pick_ok    = in_pick && btn_sel && empty && !select;
    // A select press, accepted or not, always swallows a simultaneous next.
    assign next_ok    = in_pick && btn_next && !btn_sel;

`ifdef TURN_TIMEOUT_EN
    logic [31:0] idle;
    logic        timeout_hit;

    assign timeout_hit = in_pick && !pick_ok && !next_ok && (idle == TURN_TIMEOUT - 1);

    // Count idle cycles in the pick phase; any accepted button restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle <= '0;
        end else if (!in_pick || pick_ok || next_ok || timeout_hit || x[1]) begin
            idle <= '0;
        end else begin
            idle <= idle + 32'd1;
        end
    end
`else
    // Without the timeout feature the pick phase waits indefinitely.
    logic unused_timeout;
    assign unused_timeout = ^TURN_TIMEOUT;
`endif

    // Game state machine: cursor, picks, verdict handling, show timer, scoring.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm        <= FIRST;
            cursor     <= 4'd0;
            state      <= LAYOUT[3:0];
            select     <= 1'b0;
            player     <= 1'b0;
            card_open  <= '0;
            card_done  <= '0;
            game_over  <= 1'b0;
            hold       <= '0;
            first_idx  <= 4'd0;
            second_idx <= 4'd0;
        end else begin
            // NOTE: select defaults low every cycle so any set below lasts exactly one cycle;
            // all state here uses <= so every branch sees the pre-edge values.
            select <= 1'b0;
            if (x[1]) begin
                fsm       <= GAME_OVER;
                game_over <= 1'b1;
            end else begin
                case (fsm)
                    FIRST, SECOND: begin
                        if (pick_ok) begin
                            select            <= 1'b1;
                            card_open[cursor] <= 1'b1;
                            if (fsm == FIRST) begin
                                first_idx <= cursor;
                                fsm       <= SECOND;
                            end else begin
                                second_idx <= cursor;
                                fsm        <= CHECK;
                            end
                        end else if (next_ok) begin
                            cursor <= cursor_inc;
                            state  <= card_value(cursor_inc);
                        end
`ifdef TURN_TIMEOUT_EN
                        else if (timeout_hit) begin
                            card_open <= '0;
                            player    <= ~player;
                            fsm       <= FIRST;
                        end
`endif
                    end
                    CHECK: begin
                        if (x == 2'b01) begin
                            if (par) begin
                                card_done <= card_done | pair_mask;
                                card_open <= card_open & ~pair_mask;
                                if ((card_done | pair_mask) == 16'hFFFF) begin
                                    fsm       <= GAME_OVER;
                                    game_over <= 1'b1;
                                end else begin
                                    fsm <= FIRST;
                                end
                            end else begin
                                hold <= HOLD_CYCLES;
                                fsm  <= SHOW;
                            end
                        end
                    end
                    SHOW: begin
                        if (hold <= 32'd1) begin
                            card_open <= card_open & ~pair_mask;
                            player    <= ~player;
                            hold      <= '0;
                            fsm       <= FIRST;
                        end else begin
                            hold <= hold - 32'd1;
                        end
                    end
                    default: begin
                        // GAME_OVER is absorbing; everything stays frozen.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_memory_board.sv
// tb_memory_board: directed stimulus against a turn-level game model.
// The model tracks cursor, open/done sets, picks of the turn and player;
// a negedge process compares every DUT output with it each cycle, and
// literal checks pin key results (reset values, scores, show window).
module tb_memory_board;

    localparam logic [63:0] LAYOUT  = 64'h0123_4567_7654_3210;
    localparam int          HOLD    = 4;
    localparam int          TIMEOUT = 20;

    logic        clk;
    logic        rst;
    logic        btn_next;
    logic        btn_sel;
    logic        par;
    logic [1:0]  x;
    logic [7:0]  counter;
    logic [3:0]  state;
    logic        select;
    logic        empty;
    logic        player;
    logic [15:0] card_open;
    logic [15:0] card_done;
    logic        game_over;

    memory_board #(
        .LAYOUT      (LAYOUT),
        .HOLD_CYCLES (HOLD),
        .TURN_TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_next (btn_next),
        .btn_sel  (btn_sel),
        .par      (par),
        .x        (x),
        .counter  (counter),
        .state    (state),
        .select   (select),
        .empty    (empty),
        .player   (player),
        .card_open(card_open),
        .card_done(card_done),
        .game_over(game_over)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Game model
    int        m_cursor;
    bit [15:0] m_open;
    bit [15:0] m_done;
    bit        m_player;
    bit        m_over;
    bit        m_sel;
    int        m_picks[$];
    int        m_show;
    int        m_idle;

    function automatic int card_val(input int i);
        return int'((LAYOUT >> (4 * i)) & 64'hF);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cursor = 0;
        m_open   = '0;
        m_done   = '0;
        m_player = 1'b0;
        m_over   = 1'b0;
        m_sel    = 1'b0;
        m_picks.delete();
        m_show   = 0;
        m_idle   = 0;
    endtask

    // Apply one clock edge worth of game rules to the model.
    task automatic model_edge(input bit nxt, input bit sel, input logic [1:0] xv, input bit pv);
        bit sel_was;
        bit cur_empty;
        sel_was = m_sel;
        m_sel   = 1'b0;
        if (m_over) return;
        if (xv[1]) begin
            m_over = 1'b1;
            m_idle = 0;
            return;
        end
        if (m_show > 0) begin
            m_show--;
            if (m_show == 0) begin
                foreach (m_picks[k]) m_open[m_picks[k]] = 1'b0;
                m_picks.delete();
                m_player = !m_player;
            end
            m_idle = 0;
            return;
        end
        if (m_picks.size() == 2) begin
            if (xv == 2'b01) begin
                if (pv) begin
                    foreach (m_picks[k]) begin
                        m_done[m_picks[k]] = 1'b1;
                        m_open[m_picks[k]] = 1'b0;
                    end
                    m_picks.delete();
                    if (m_done == 16'hFFFF) m_over = 1'b1;
                end else begin
                    m_show = HOLD;
                end
            end
            m_idle = 0;
            return;
        end
        cur_empty = !m_open[m_cursor] && !m_done[m_cursor];
        if (sel && cur_empty && !sel_was) begin
            m_open[m_cursor] = 1'b1;
            m_picks.push_back(m_cursor);
            m_sel  = 1'b1;
            m_idle = 0;
        end else if (nxt && !sel) begin
            m_cursor = (m_cursor + 1) % 16;
            m_idle   = 0;
        end
`ifdef TURN_TIMEOUT_EN
        else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_open = '0;
                m_picks.delete();
                m_player = !m_player;
                m_idle   = 0;
            end
        end
`endif
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("counter", counter, m_cursor);
            check("state", state, card_val(m_cursor));
            check("select", select, m_sel);
            check("empty", empty, !m_open[m_cursor] && !m_done[m_cursor]);
            check("player", player, m_player);
            check("card_open", card_open, m_open);
            check("card_done", card_done, m_done);
            check("game_over", game_over, m_over);
        end
    end

    // NOTE: inputs are driven with blocking assignments 1ns after the edge,
    // so the DUT always samples stable values at the next posedge.
    task automatic cycle(input bit nxt, input bit sel, input logic [1:0] xv, input bit pv);
        btn_next = nxt;
        btn_sel  = sel;
        x        = xv;
        par      = pv;
        @(posedge clk);
        #1;
        btn_next = 1'b0;
        btn_sel  = 1'b0;
        x        = 2'b00;
        par      = 1'b0;
        model_edge(nxt, sel, xv, pv);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic pick();
        cycle(1'b0, 1'b1, 2'b00, 1'b0);
    endtask

    task automatic goto(input int target);
        for (int k = 0; k < 16 && m_cursor != target; k++) cycle(1'b1, 1'b0, 2'b00, 1'b0);
    endtask

    // Select pulse cycle, then the checker's verdict one cycle later.
    task automatic verdict(input bit pv);
        idle();
        cycle(1'b0, 1'b0, 2'b01, pv);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        #1;
        check("rst_counter", counter, 32'd0);
        check("rst_state", state, 32'd0);
        check("rst_select", select, 32'd0);
        check("rst_empty", empty, 32'd1);
        check("rst_player", player, 32'd0);
        check("rst_open", card_open, 32'd0);
        check("rst_done", card_done, 32'd0);
        check("rst_game_over", game_over, 32'd0);
        model_reset();
        chk_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        btn_next = 1'b0;
        btn_sel  = 1'b0;
        par      = 1'b0;
        x        = 2'b00;
        model_reset();
        @(posedge clk);
        #1;
        reset_dut();

        // Match of the corner cards 0 and 15.
        pick();
        for (int k = 0; k < 15; k++) cycle(1'b1, 1'b0, 2'b00, 1'b0);
        check("cursor_at_15", counter, 32'd15);
        pick();
        verdict(1'b1);
        check("match_done", card_done, 32'h8001);
        check("match_open", card_open, 32'h0000);
        check("match_player", player, 32'd0);

        // Mismatch of cards 1 and 2, shown for HOLD cycles.
        goto(1);
        pick();
        goto(2);
        pick();
        verdict(1'b0);
        check("show_open_0", card_open, 32'h0006);
        for (int k = 1; k < HOLD; k++) begin
            idle();
            check("show_open_n", card_open, 32'h0006);
        end
        idle();
        check("show_end_open", card_open, 32'h0000);
        check("show_end_player", player, 32'd1);

        // Repeat select on an already open card is ignored.
        goto(3);
        pick();
        idle();
        pick();
        check("repick_select", select, 32'd0);
        check("repick_open", card_open, 32'h0008);
        goto(12);
        pick();
        check("second_select", select, 32'd1);
        verdict(1'b1);
        check("second_done", card_done, 32'h9009);
        check("second_player", player, 32'd1);

        // Sixteen next presses wrap the cursor; x=10 ends the game.
        reset_dut();
        for (int k = 0; k < 16; k++) cycle(1'b1, 1'b0, 2'b00, 1'b0);
        check("wrap_counter", counter, 32'd0);
        check("wrap_state", state, 32'd0);
        cycle(1'b1, 1'b0, 2'b00, 1'b0);
        cycle(1'b0, 1'b0, 2'b10, 1'b0);
        check("x10_game_over", game_over, 32'd1);
        cycle(1'b1, 1'b0, 2'b00, 1'b0);
        pick();
        check("frozen_counter", counter, 32'd1);
        check("frozen_select", select, 32'd0);

        // Reset in the middle of SHOW discards the turn.
        reset_dut();
        goto(1);
        pick();
        goto(2);
        pick();
        verdict(1'b0);
        idle();
        reset_dut();
        check("post_rst_open", card_open, 32'h0000);

        // Clearing the whole board ends the game.
        for (int i = 0; i < 8; i++) begin
            goto(i);
            pick();
            goto(15 - i);
            pick();
            verdict(1'b1);
        end
        check("board_done", card_done, 32'hFFFF);
        check("board_game_over", game_over, 32'd1);
        cycle(1'b1, 1'b0, 2'b00, 1'b0);
        check("board_frozen", counter, 32'd8);

`ifdef TURN_TIMEOUT_EN
        // Idle turn times out after TIMEOUT cycles.
        reset_dut();
        goto(3);
        pick();
        for (int k = 1; k < TIMEOUT; k++) idle();
        check("pre_timeout_open", card_open, 32'h0008);
        check("pre_timeout_player", player, 32'd0);
        idle();
        check("timeout_open", card_open, 32'h0000);
        check("timeout_player", player, 32'd1);
        check("timeout_select", select, 32'd0);
`endif

        idle();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_board.md
MEMORY_BOARD -- requirements
Module: memory_board

Interface
REQ-001 Parameter LAYOUT, default 64'h0123_4567_7654_3210, card values; nibble i is the 4-bit value of card i (16 cards, 8 pairs).
REQ-002 Parameter HOLD_CYCLES, default 25_000_000, cycles a mismatched pair stays revealed (1..2^32-1).
REQ-003 Parameter TURN_TIMEOUT, default 250_000_000, idle cycles allowed in a turn (used only with TURN_TIMEOUT_EN).
REQ-004 clk  in  1  single clock; all state changes on posedge clk.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 btn_next  in  1  single-cycle debounced pulse; advance cursor.
REQ-007 btn_sel  in  1  single-cycle debounced pulse; pick card under cursor.
REQ-008 par  in  1  pair verdict from turn checker; 1 = match; valid while x==2'b01.
REQ-009 x  in  2  checker status: 00 idle, 01 verdict valid, 10 winner decided, 11 tie.
REQ-010 counter  out  8  registered cursor index, 0..15; bits [7:4] always 0.
REQ-011 state  out  4  registered value of card under cursor (LAYOUT nibble at counter).
REQ-012 select  out  1  registered single-cycle pulse presenting counter/state to the checker.
REQ-013 empty  out  1  1 when card under cursor is neither open nor done.
REQ-014 player  out  1  current player (0 or 1).
REQ-015 card_open  out  16  bit i = card i currently revealed this turn.
REQ-016 card_done  out  16  bit i = card i permanently matched.
REQ-017 game_over  out  1  1 in GAME_OVER state.

Function
REQ-018 FSM states FIRST, SECOND, CHECK, SHOW, GAME_OVER; reset state FIRST.
REQ-019 btn_next in FIRST/SECOND: counter <= (counter+1) mod 16; state follows next cycle-consistent with counter (same edge).
REQ-020 btn_sel in FIRST/SECOND with empty=1: next cycle select=1, card_open[counter]=1, index stored; counter/state unchanged during the pulse.
REQ-021 btn_sel with empty=0: ignored; no select pulse, no state change.
REQ-022 btn_sel and btn_next in same cycle: select handled, btn_next dropped.
REQ-023 Accepted pick in FIRST -> SECOND; accepted pick in SECOND -> CHECK.
REQ-024 Buttons ignored in CHECK, SHOW, GAME_OVER.
REQ-025 CHECK waits for x==2'b01, then samples par on that edge.
REQ-026 par=1: card_done |= both bits, card_open clears both bits, player unchanged; -> GAME_OVER if card_done becomes 16'hFFFF, else FIRST.
REQ-027 par=0: -> SHOW, hold counter loaded with HOLD_CYCLES.
REQ-028 SHOW: counter decrements each cycle; on reaching 0 clear both card_open bits, toggle player, -> FIRST (total HOLD_CYCLES cycles in SHOW).
REQ-029 x==2'b10 or 2'b11 in any state: -> GAME_OVER next edge, overriding all other transitions.
REQ-030 GAME_OVER: absorbing until rst; outputs frozen except select=0.
REQ-031 select never high two consecutive cycles; at most two pulses per turn.

Reset
REQ-032 rst=1 asynchronously forces: FIRST, counter=0, state=LAYOUT[3:0], select=0, player=0, card_open=0, card_done=0, game_over=0, timers=0.
REQ-033 rst asserted mid-SHOW/CHECK discards the pending turn with no verdict applied.

Configuration
REQ-034 Macro TURN_TIMEOUT_EN defined: idle counter runs in FIRST/SECOND, cleared by any accepted button; at TURN_TIMEOUT idle cycles, card_open cleared, player toggled, -> FIRST, no select pulse.
REQ-035 TURN_TIMEOUT_EN undefined: no timer logic; FIRST/SECOND wait indefinitely.

Verification (HOLD_CYCLES=4, TURN_TIMEOUT=20, checker model returns x=01 one cycle after second select)
REQ-036 Reset -> counter=0, state=0, select=0, empty=1, player=0, card_open=0, card_done=0.
REQ-037 Pick card 0, 15 btn_next, pick card 15, par=1 -> card_done=16'h8001, card_open=0, player=0.
REQ-038 Pick cards 1 and 2, par=0 -> card_open=16'h0006 for 4 SHOW cycles, then 0; player=1.
REQ-039 Pick card 0 then btn_sel again on card 0 -> no second select pulse, state stays SECOND.
REQ-040 16 btn_next pulses from reset -> counter back to 0, state=0; x=2'b10 any time -> game_over=1.
REQ-041 With TURN_TIMEOUT_EN: pick card 3, idle 20 cycles -> card_open=0, player=1, no select pulse.
